// File: rtl/mxrv_rom_arbiter.sv
// Shares a single-read-port instruction ROM between instruction fetch (IF) and loads (LS).
// Keeps one read outstanding, gives IF priority, and limits IF streaks so LS is not starved.
module mxrv_rom_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ready_o,
  input  logic              if_flush_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_valid_o,
  input  logic              ls_req_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  output logic              ls_ready_o,
  output logic [DATA_W-1:0] ls_data_o,
  output logic              ls_valid_o,
  output logic              rom_rd_valid_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic              rom_rd_ready_i,
  input  logic [DATA_W-1:0] rom_data_i,
  input  logic              rom_valid_i
);

  // Handshake: a request transfers in the cycle where *_req_i and *_ready_o are both 1
  // (likewise rom_rd_valid_o/rom_rd_ready_i); requesters hold request and address until then.
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS} state_e;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  state_e            state_q, state_d;
  logic [3:0]        streak_q, streak_d;
  logic              drop_q, drop_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] ls_data_q, ls_data_d;
  logic              if_valid_q, if_valid_d;
  logic              ls_valid_q, ls_valid_d;

  logic slot_free, can_issue, grant_if, grant_ls;
  logic if_ret, ls_ret, drop_now;

  always_comb begin
    slot_free = (state_q == IDLE) | rom_valid_i;
    // Grants are suppressed while reset is held so every output reads 0 immediately.
    can_issue = rst_n & slot_free & rom_rd_ready_i;
    grant_ls  = can_issue & ls_req_i & (~if_req_i | (streak_q == STREAK_MAX));
    grant_if  = can_issue & if_req_i & ~grant_ls;

    if_ret   = rom_valid_i & (state_q == BUSY_IF);
    ls_ret   = rom_valid_i & (state_q == BUSY_LS);
    drop_now = drop_q | (if_flush_i & (state_q == BUSY_IF));

    state_d = state_q;
    if (grant_if)              state_d = BUSY_IF;
    else if (grant_ls)         state_d = BUSY_LS;
    else if (if_ret | ls_ret)  state_d = IDLE;

    streak_d = streak_q;
    if (!ls_req_i || grant_ls)                  streak_d = 4'd0;
    else if (grant_if && streak_q != STREAK_MAX) streak_d = streak_q + 4'd1;

    // The drop flag belongs to the read being returned; a grant in the same cycle starts clean.
    drop_d     = if_ret ? 1'b0 : drop_now;
    if_valid_d = if_ret & ~drop_now;
    if_data_d  = (if_ret & ~drop_now) ? rom_data_i : if_data_q;
    ls_valid_d = ls_ret;
    ls_data_d  = ls_ret ? rom_data_i : ls_data_q;

    if_ready_o     = grant_if;
    ls_ready_o     = grant_ls;
    rom_rd_valid_o = grant_if | grant_ls;
    rom_addr_o     = '0;
    if (grant_if)      rom_addr_o = if_addr_i;
    else if (grant_ls) rom_addr_o = ls_addr_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      streak_q   <= 4'd0;
      drop_q     <= 1'b0;
      if_data_q  <= '0;
      ls_data_q  <= '0;
      if_valid_q <= 1'b0;
      ls_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      drop_q     <= drop_d;
      if_data_q  <= if_data_d;
      ls_data_q  <= ls_data_d;
      if_valid_q <= if_valid_d;
      ls_valid_q <= ls_valid_d;
    end
  end

  assign if_data_o  = if_data_q;
  assign if_valid_o = if_valid_q;
  assign ls_data_o  = ls_data_q;
  assign ls_valid_o = ls_valid_q;

endmodule
